// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Two-read / one-write register file with an issue scoreboard,
//            optional hardwired-zero register 0 and write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic             Clk,
  input  logic             Clrn,
  input  logic             We,
  input  logic [AW-1:0]    Wa,
  input  logic [WIDTH-1:0] Wd,
  input  logic [AW-1:0]    Ra1,
  input  logic [AW-1:0]    Ra2,
  output logic [WIDTH-1:0] Rd1,
  output logic [WIDTH-1:0] Rd2,
  output logic             Rdy1,
  output logic             Rdy2,
  input  logic             Iss,
  input  logic [AW-1:0]    Ia,
  output logic [DEPTH-1:0] Busy
);

  localparam int          IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
  localparam bit          HAS_ZERO = (ZERO_REG != 0);
  localparam bit          HAS_BYP  = (BYPASS != 0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic w_wr_legal;
  logic w_iss_legal;

  assign w_wr_legal  = We  && ({1'b0, Wa} < DEPTH_W) && !(HAS_ZERO && (Wa == '0));
  assign w_iss_legal = Iss && ({1'b0, Ia} < DEPTH_W) && !(HAS_ZERO && (Ia == '0));

  // Issue is applied after the write so a same-cycle issue keeps the bit set.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (w_wr_legal) begin
      mem_d[Wa[IW-1:0]]  = Wd;
      busy_d[Wa[IW-1:0]] = 1'b0;
    end
    if (w_iss_legal) begin
      busy_d[Ia[IW-1:0]] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  // Returns {rdy, data}; forwarding is gated by Clrn so reset reads stay zero.
  function automatic logic [WIDTH:0] read_port(input logic [AW-1:0] ra);
    logic [WIDTH-1:0] data;
    logic             rdy;
    data = '0;
    rdy  = 1'b1;
    if (HAS_BYP && Clrn && w_wr_legal && (Wa == ra)) begin
      data = Wd;
    end else if (({1'b0, ra} < DEPTH_W) && !(HAS_ZERO && (ra == '0))) begin
      data = mem_q[ra[IW-1:0]];
      rdy  = !busy_q[ra[IW-1:0]];
    end
    return {rdy, data};
  endfunction

  assign {Rdy1, Rd1} = read_port(Ra1);
  assign {Rdy2, Rd2} = read_port(Ra2);
  assign Busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Directed self-checking bench for regfile_sb (default build and a
//            16x8 no-zero-register, no-forwarding build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic        clk;
  logic        clrn;

  // Default-parameter instance
  logic        we, iss;
  logic [4:0]  wa, ra1, ra2, ia;
  logic [31:0] wd, rd1, rd2, busy;
  logic        rdy1, rdy2;

  // WIDTH=16 DEPTH=8 AW=4 ZERO_REG=0 BYPASS=0 instance
  logic        b_we, b_iss;
  logic [3:0]  b_wa, b_ra1, b_ra2, b_ia;
  logic [15:0] b_wd, b_rd1, b_rd2;
  logic [7:0]  b_busy;
  logic        b_rdy1, b_rdy2;

  int errors = 0;
  int checks = 0;

  regfile_sb u_dut (
    .Clk(clk), .Clrn(clrn), .We(we), .Wa(wa), .Wd(wd),
    .Ra1(ra1), .Ra2(ra2), .Rd1(rd1), .Rd2(rd2), .Rdy1(rdy1), .Rdy2(rdy2),
    .Iss(iss), .Ia(ia), .Busy(busy)
  );

  regfile_sb #(.WIDTH(16), .DEPTH(8), .AW(4), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .Clk(clk), .Clrn(clrn), .We(b_we), .Wa(b_wa), .Wd(b_wd),
    .Ra1(b_ra1), .Ra2(b_ra2), .Rd1(b_rd1), .Rd2(b_rd2), .Rdy1(b_rdy1), .Rdy2(b_rdy2),
    .Iss(b_iss), .Ia(b_ia), .Busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clrn = 1'b0;
    we = 0; iss = 0; wa = 0; ra1 = 0; ra2 = 0; ia = 0; wd = 0;
    b_we = 0; b_iss = 0; b_wa = 0; b_ra1 = 0; b_ra2 = 0; b_ia = 0; b_wd = 0;
    tick();
    tick();
    #2 clrn = 1'b1;
    tick();

    // Reset state across every address
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      #1;
      chk($sformatf("rst_rd1[%0d]", a), {32'd0, rd1}, 64'd0);
      chk($sformatf("rst_rd2[%0d]", 31 - a), {32'd0, rd2}, 64'd0);
      chk($sformatf("rst_rdy[%0d]", a), {62'd0, rdy1, rdy2}, 64'd3);
    end
    chk("rst_busy", {32'd0, busy}, 64'd0);

    // Plain write then read next cycle
    we = 1; wa = 5; wd = 32'hDEADBEEF;
    tick();
    we = 0; ra1 = 5;
    #1 chk("rd_reg5", {32'd0, rd1}, 64'hDEADBEEF);

    // Register 0 is hardwired, no forwarding either
    we = 1; wa = 0; wd = 32'h1234; ra2 = 0;
    #1 chk("rd_reg0_samecyc", {32'd0, rd2}, 64'd0);
    chk("rdy_reg0_samecyc", {63'd0, rdy2}, 64'd1);
    tick();
    we = 0;
    #1 chk("rd_reg0_after", {32'd0, rd2}, 64'd0);

    // Issue marks pending, write with forwarding clears it
    iss = 1; ia = 7;
    tick();
    iss = 0; ra1 = 7;
    #1 chk("rdy_7_pending", {63'd0, rdy1}, 64'd0);
    chk("busy_7_set", {32'd0, busy}, 64'h80);
    we = 1; wa = 7; wd = 32'h55;
    #1 chk("byp_rd_7", {32'd0, rd1}, 64'h55);
    chk("byp_rdy_7", {63'd0, rdy1}, 64'd1);
    tick();
    we = 0;
    #1 chk("busy_7_clr", {32'd0, busy}, 64'd0);
    chk("rd_7_stored", {32'd0, rd1}, 64'h55);

    // Same-cycle issue and write: set wins, data still written
    iss = 1; ia = 9; we = 1; wa = 9; wd = 32'hA5;
    tick();
    iss = 0; we = 0; ra1 = 9; ra2 = 9;
    #1 chk("rd1_9", {32'd0, rd1}, 64'hA5);
    chk("rd2_9", {32'd0, rd2}, 64'hA5);
    chk("rdy_9_both", {62'd0, rdy1, rdy2}, 64'd0);
    chk("busy_9", {32'd0, busy}, 64'h200);

    // Issue to register 0 is ignored
    iss = 1; ia = 0; ra1 = 0;
    tick();
    iss = 0;
    #1 chk("busy_iss0_ignored", {32'd0, busy}, 64'h200);
    chk("rdy_reg0", {63'd0, rdy1}, 64'd1);

    // Asynchronous reset mid-cycle
    we = 1; wa = 3; wd = 32'hFFFFFFFF; iss = 1; ia = 4;
    tick();
    we = 0; iss = 0; ra1 = 3; ra2 = 9;
    #1 chk("rd_reg3_pre", {32'd0, rd1}, 64'hFFFFFFFF);
    chk("busy_pre_rst", {32'd0, busy}, 64'h210);
    #1 clrn = 1'b0; we = 1; wa = 3; wd = 32'h1;
    #1 chk("rst_async_rd3", {32'd0, rd1}, 64'd0);
    chk("rst_async_rd9", {32'd0, rd2}, 64'd0);
    chk("rst_async_busy", {32'd0, busy}, 64'd0);
    chk("rst_async_rdy", {62'd0, rdy1, rdy2}, 64'd3);
    iss = 1; ia = 3;
    tick();
    chk("rst_hold_rd3", {32'd0, rd1}, 64'd0);
    chk("rst_hold_busy", {32'd0, busy}, 64'd0);
    we = 0; iss = 0;
    #2 clrn = 1'b1;
    tick();
    chk("post_rst_rd3", {32'd0, rd1}, 64'd0);

    // Alternate build: register 0 is ordinary, no forwarding
    b_we = 1; b_wa = 0; b_wd = 16'hBEEF; b_ra1 = 0;
    #1 chk("b_rd0_samecyc", {48'd0, b_rd1}, 64'd0);
    tick();
    b_we = 0;
    #1 chk("b_rd0_next", {48'd0, b_rd1}, 64'hBEEF);
    b_ra2 = 9;
    #1 chk("b_rd_oob", {48'd0, b_rd2}, 64'd0);
    chk("b_rdy_oob", {63'd0, b_rdy2}, 64'd1);
    b_iss = 1; b_ia = 0;
    tick();
    b_iss = 1; b_ia = 9;
    #1 chk("b_rdy0_pending", {63'd0, b_rdy1}, 64'd0);
    chk("b_busy0", {56'd0, b_busy}, 64'h01);
    tick();
    b_iss = 0;
    #1 chk("b_busy_oob_iss", {56'd0, b_busy}, 64'h01);
    b_we = 1; b_wa = 0; b_wd = 16'h1111;
    #1 chk("b_rdy0_nobyp", {63'd0, b_rdy1}, 64'd0);
    chk("b_rd0_nobyp", {48'd0, b_rd1}, 64'hBEEF);
    tick();
    b_we = 0;
    #1 chk("b_busy0_clr", {56'd0, b_busy}, 64'd0);
    chk("b_rd0_new", {48'd0, b_rd1}, 64'h1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL provide parameter DEPTH, default 32, number of registers (2..256).
REQ-003 SHALL provide parameter AW, default 5, address width; DEPTH <= 2**AW.
REQ-004 SHALL provide parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-005 SHALL provide parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding.
REQ-006 Clk  input  1  single clock; all state updates on rising edge.
REQ-007 Clrn  input  1  asynchronous active-low reset.
REQ-008 We  input  1  write enable.
REQ-009 Wa  input  AW  write address.
REQ-010 Wd  input  WIDTH  write data.
REQ-011 Ra1, Ra2  input  AW  read addresses, ports 1 and 2.
REQ-012 Rd1, Rd2  output  WIDTH  read data, ports 1 and 2.
REQ-013 Rdy1, Rdy2  output  1  operand valid (no pending write to that register).
REQ-014 Iss  input  1  issue: mark register Ia pending.
REQ-015 Ia  input  AW  issue destination address.
REQ-016 Busy  output  DEPTH  scoreboard vector, bit i = register i pending.

Function
REQ-017 Write: on rising Clk with We=1, Wa<DEPTH, and not (ZERO_REG=1 and Wa=0), register Wa SHALL take Wd; all other writes ignored.
REQ-018 Reads SHALL be combinational, zero latency.
REQ-019 Read of Ra>=DEPTH SHALL return 0 and Rdy=1.
REQ-020 Read of register 0 with ZERO_REG=1 SHALL return 0 and Rdy=1 regardless of Busy or We.
REQ-021 BYPASS=1: when We=1 and Wa=Ra and the write is legal per REQ-017, Rd SHALL equal Wd in the same cycle; BYPASS=0: Rd SHALL show the stored value until the following edge.
REQ-022 Ports 1 and 2 SHALL be independent; equal addresses SHALL return identical data and Rdy.
REQ-023 Scoreboard: on rising Clk, Iss=1 with Ia<DEPTH SHALL set Busy[Ia]; a legal write SHALL clear Busy[Wa].
REQ-024 Iss and a legal write to the same address in the same cycle: set SHALL win (Busy stays/becomes 1; data still written).
REQ-025 Iss to Ia>=DEPTH, or Ia=0 with ZERO_REG=1, SHALL be ignored.
REQ-026 Rdy SHALL be !Busy[Ra], OR'ed with the bypass condition of REQ-021 when BYPASS=1.
REQ-027 A write to a non-busy register SHALL be accepted normally (Busy remains 0).
REQ-028 Busy[0] SHALL read constant 0 when ZERO_REG=1.

Reset
REQ-029 Clrn=0 SHALL asynchronously clear all registers to 0 and all Busy bits to 0, independent of Clk.
REQ-030 While Clrn=0, writes and issues SHALL be ignored; Rd outputs SHALL read 0 except same-cycle bypass is suppressed.
REQ-031 Release of Clrn SHALL be taken as synchronous to Clk; first update at the first rising edge with Clrn=1.

Verification
REQ-032 Reset, then read all addresses -> Rd1=Rd2=0, Rdy1=Rdy2=1, Busy=0.
REQ-033 Write Wa=5 Wd=0xDEADBEEF, next cycle Ra1=5 -> Rd1=0xDEADBEEF; write Wa=0 Wd=0x1234 -> Ra2=0 gives 0.
REQ-034 Iss Ia=7; next cycle Ra1=7 -> Rdy1=0, Busy[7]=1; then We Wa=7 Wd=0x55 with Ra1=7 -> same cycle Rd1=0x55, Rdy1=1 (BYPASS=1); after edge Busy[7]=0.
REQ-035 Same cycle Iss Ia=9 and We Wa=9 Wd=0xA5 -> after edge reg9=0xA5, Busy[9]=1, Rdy for 9 = 0.
REQ-036 Write 0xFFFFFFFF to reg 3 and Iss Ia=4, assert Clrn=0 mid-cycle without clock -> reg3 reads 0, Busy=0 immediately.
REQ-037 Parameter sweep WIDTH=16 DEPTH=8 ZERO_REG=0 BYPASS=0: write reg0=0xBEEF -> reads 0xBEEF next cycle, not same cycle; Ra=9 (AW=4) -> Rd=0, Rdy=1.
